// File: rtl/prog_ram.sv
// prog_ram: single-port program RAM with CPU access and a streaming program loader.
// Ports:
//   clk, rst_n            - rising-edge clock, asynchronous active-low reset
//   din, addr, we, re     - CPU write data, address, write and read enables
//   dout, dout_valid      - registered CPU read data and its one-cycle valid flag
//   cpu_stall             - high while the loader owns the memory (CPU accesses dropped)
//   ld_start, ld_base,    - loader start pulse, first address and word count
//   ld_len                  (base and count are sampled on an accepted start)
//   ld_data, ld_valid     - loader word stream
//   ld_ready, ld_busy,    - loader handshake, load-in-progress, completion pulse
//   ld_done
module prog_ram #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              cpu_stall,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned REM_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [REM_W-1:0]   remaining;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               cpu_rd_c;
  logic               cpu_wr_c;
  logic               ld_wr_c;
  logic               mem_wr_c;
  logic [ADDR_W-1:0]  wr_addr_c;
  logic [DATA_W-1:0]  wr_data_c;
  logic [REM_W-1:0]   len_clamped_c;

  // CPU is locked out whenever the loader is not idle; loader writes only in LOAD,
  // so the two write sources never collide on the single write port.
  always_comb begin
    cpu_rd_c      = re & ~cpu_stall;
    cpu_wr_c      = we & ~cpu_stall;
    ld_wr_c       = (state == LOAD) & ld_valid;
    mem_wr_c      = cpu_wr_c | ld_wr_c;
    wr_addr_c     = ld_wr_c ? ptr : addr;
    wr_data_c     = ld_wr_c ? ld_data : din;
    len_clamped_c = (ld_len > REM_W'(DEPTH)) ? REM_W'(DEPTH) : ld_len;
  end

  // Storage array; deliberately not reset so loaded code survives a reset.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  // Registered read port; write-first mode forwards din on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= cpu_rd_c;
      if (cpu_rd_c) begin
        dout <= ((WR_MODE == 1) && cpu_wr_c) ? din : mem[addr];
      end
    end
  end

  // Loader FSM; status outputs are registered alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      ld_ready  <= 1'b0;
      ld_busy   <= 1'b0;
      ld_done   <= 1'b0;
      cpu_stall <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ld_start) begin
            ptr       <= ld_base;
            remaining <= len_clamped_c;
            ld_busy   <= 1'b1;
            cpu_stall <= 1'b1;
            if (ld_len == '0) begin
              // Empty load: report completion without touching memory.
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end else begin
              state    <= LOAD;
              ld_ready <= 1'b1;
              ld_done  <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          ld_ready  <= 1'b0;
          ld_done   <= 1'b0;
          ld_busy   <= 1'b0;
          cpu_stall <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ld_ready  <= 1'b0;
          ld_done   <= 1'b0;
          ld_busy   <= 1'b0;
          cpu_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
